// File: rtl/if_stage_if.sv
// Instruction-memory fetch channel: request/address out, ready/data back.
interface if_stage_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              ready;
  logic [31:0]       rdata;

  modport master (output req, output addr, input ready, input rdata);
  modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage with IF/ID register, one-entry skid buffer
// for hazard stalls, and squash/refetch on branch or jump redirects.
module if_stage #(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  if_stage_if.master        imem,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_id_valid,
  output logic [31:0]       if_id_instr,
  output logic [ADDR_W-1:0] if_id_pc4,
  output logic [5:0]        opcode,
  output logic [5:0]        func
);

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_req_q, pc_req_d;
  logic [ADDR_W-1:0] pc_pend_q, pc_pend_d;
  logic [31:0]       skid_instr_q, skid_instr_d;
  logic [ADDR_W-1:0] skid_pc4_q, skid_pc4_d;
  logic              if_id_valid_q, if_id_valid_d;
  logic [31:0]       if_id_instr_q, if_id_instr_d;
  logic [ADDR_W-1:0] if_id_pc4_q, if_id_pc4_d;

  logic [ADDR_W-1:0] redir_pc_s;
  logic [ADDR_W-1:0] pc_next4_s;

  assign redir_pc_s = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign pc_next4_s = pc_req_q + PC_STEP;

  // Next-state, fetch PC, skid and IF/ID selection; priority redirect > stall > normal
  always_comb begin
    state_d       = state_q;
    pc_req_d      = pc_req_q;
    pc_pend_d     = pc_pend_q;
    skid_instr_d  = skid_instr_q;
    skid_pc4_d    = skid_pc4_q;
    if_id_valid_d = if_id_valid_q;
    if_id_instr_d = if_id_instr_q;
    if_id_pc4_d   = if_id_pc4_q;

    case (state_q)
      ST_REQ: begin
        if (redirect_valid) begin
          if_id_valid_d = 1'b0;
          if_id_instr_d = 32'h0000_0000;
          if (imem.ready) begin
            pc_req_d = redir_pc_s;
          end else begin
            pc_pend_d = redir_pc_s;
            state_d   = ST_DRAIN;
          end
        end else if (imem.ready) begin
          pc_req_d = pc_next4_s;
          if (stall) begin
            skid_instr_d = imem.rdata;
            skid_pc4_d   = pc_next4_s;
            state_d      = ST_HOLD;
          end else begin
            if_id_valid_d = 1'b1;
            if_id_instr_d = imem.rdata;
            if_id_pc4_d   = pc_next4_s;
          end
        end else if (!stall) begin
          if_id_valid_d = 1'b0;
          if_id_instr_d = 32'h0000_0000;
        end else begin
          state_d = ST_REQ;
        end
      end

      ST_HOLD: begin
        if (redirect_valid) begin
          pc_req_d      = redir_pc_s;
          if_id_valid_d = 1'b0;
          if_id_instr_d = 32'h0000_0000;
          state_d       = ST_REQ;
        end else if (!stall) begin
          if_id_valid_d = 1'b1;
          if_id_instr_d = skid_instr_q;
          if_id_pc4_d   = skid_pc4_q;
          state_d       = ST_REQ;
        end else begin
          state_d = ST_HOLD;
        end
      end

      // Old request still in flight: keep its address, discard its data
      ST_DRAIN: begin
        if_id_valid_d = 1'b0;
        if_id_instr_d = 32'h0000_0000;
        if (redirect_valid) begin
          if (imem.ready) begin
            pc_req_d = redir_pc_s;
            state_d  = ST_REQ;
          end else begin
            pc_pend_d = redir_pc_s;
          end
        end else if (imem.ready) begin
          pc_req_d = pc_pend_q;
          state_d  = ST_REQ;
        end else begin
          state_d = ST_DRAIN;
        end
      end

      default: begin
        state_d       = ST_REQ;
        if_id_valid_d = 1'b0;
        if_id_instr_d = 32'h0000_0000;
      end
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_REQ;
      pc_req_q      <= RESET_PC;
      pc_pend_q     <= {ADDR_W{1'b0}};
      skid_instr_q  <= 32'h0000_0000;
      skid_pc4_q    <= {ADDR_W{1'b0}};
      if_id_valid_q <= 1'b0;
      if_id_instr_q <= 32'h0000_0000;
      if_id_pc4_q   <= {ADDR_W{1'b0}};
    end else begin
      state_q       <= state_d;
      pc_req_q      <= pc_req_d;
      pc_pend_q     <= pc_pend_d;
      skid_instr_q  <= skid_instr_d;
      skid_pc4_q    <= skid_pc4_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc4_q   <= if_id_pc4_d;
    end
  end

  assign imem.req    = (state_q != ST_HOLD);
  assign imem.addr   = pc_req_q;
  assign if_id_valid = if_id_valid_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_pc4   = if_id_pc4_q;
  assign opcode      = if_id_instr_q[31:26];
  assign func        = if_id_instr_q[5:0];

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios, then randomized traffic compared
// against a queue-based model of the fetch pipeline.
module tb_if_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic [5:0]  opcode;
  logic [5:0]  func;

  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_pc4;
  logic [5:0]  w_opcode;
  logic [5:0]  w_func;

  if_stage_if #(.ADDR_W(32)) bus ();
  if_stage_if #(.ADDR_W(32)) bus_w ();

  assign bus_w.ready = 1'b1;
  assign bus_w.rdata = 32'h0000_0000;

  if_stage #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem           (bus.master),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc4      (if_id_pc4),
    .opcode         (opcode),
    .func           (func)
  );

  if_stage #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk            (clk),
    .rst            (rst),
    .imem           (bus_w.master),
    .stall          (1'b0),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0000_0000),
    .if_id_valid    (w_valid),
    .if_id_instr    (w_instr),
    .if_id_pc4      (w_pc4),
    .opcode         (w_opcode),
    .func           (w_func)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: fetch PC, pending redirect target, skid as a queue, IF/ID contents
  bit          m_known = 1'b0;
  logic [31:0] m_pc;
  logic [31:0] m_target;
  bit          m_drain;
  logic [63:0] m_skid[$];
  logic        m_v;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0020) return 32'h0123_4820;
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic        fire;
    logic [31:0] rpc;
    logic [63:0] e;
    fire = (m_skid.size() == 0) && (bus.ready === 1'b1);
    rpc  = {redirect_pc[31:2], 2'b00};
    if (rst) begin
      m_known = 1'b1;
      m_pc    = 32'h0000_0000;
      m_drain = 1'b0;
      m_skid.delete();
      m_v     = 1'b0;
      m_instr = 32'h0000_0000;
      m_pc4   = 32'h0000_0000;
    end else if (redirect_valid) begin
      m_v     = 1'b0;
      m_instr = 32'h0000_0000;
      if (m_skid.size() != 0 || fire) begin
        m_pc    = rpc;
        m_drain = 1'b0;
      end else begin
        m_drain  = 1'b1;
        m_target = rpc;
      end
      m_skid.delete();
    end else if (m_drain) begin
      m_v     = 1'b0;
      m_instr = 32'h0000_0000;
      if (fire) begin
        m_pc    = m_target;
        m_drain = 1'b0;
      end
    end else if (m_skid.size() != 0) begin
      if (!stall) begin
        e       = m_skid.pop_front();
        m_v     = 1'b1;
        m_instr = e[63:32];
        m_pc4   = e[31:0];
      end
    end else if (fire) begin
      if (stall) begin
        m_skid.push_back({mem_word(m_pc), m_pc + 32'd4});
      end else begin
        m_v     = 1'b1;
        m_instr = mem_word(m_pc);
        m_pc4   = m_pc + 32'd4;
      end
      m_pc = m_pc + 32'd4;
    end else if (!stall) begin
      m_v     = 1'b0;
      m_instr = 32'h0000_0000;
    end
  endtask

  // One clock: check handshake outputs before the edge, IF/ID after it
  task automatic tick();
    bus.rdata = bus.ready ? mem_word(m_pc) : $urandom();
    if (m_known) begin
      chk("imem_req", 32'(bus.req), 32'(m_skid.size() == 0));
      if (m_skid.size() == 0) chk("imem_addr", bus.addr, m_pc);
    end
    @(posedge clk);
    model_step();
    #1;
    chk("if_id_valid", 32'(if_id_valid), 32'(m_v));
    chk("if_id_instr", if_id_instr, m_instr);
    if (m_v) chk("if_id_pc4", if_id_pc4, m_pc4);
    chk("opcode", 32'(opcode), 32'(m_instr[31:26]));
    chk("func", 32'(func), 32'(m_instr[5:0]));
  endtask

  initial begin
    rst            = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0000_0000;
    bus.ready      = 1'b0;
    bus.rdata      = 32'h0000_0000;
    m_pc           = 32'h0000_0000;
    m_target       = 32'h0000_0000;
    m_drain        = 1'b0;
    m_v            = 1'b0;
    m_instr        = 32'h0000_0000;
    m_pc4          = 32'h0000_0000;

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    chk("rst_req", 32'(bus.req), 32'h1);
    chk("rst_addr", bus.addr, 32'h0000_0000);
    chk("rst_valid", 32'(if_id_valid), 32'h0);
    chk("rst_instr", if_id_instr, 32'h0000_0000);
    chk("rst_pc4", if_id_pc4, 32'h0000_0000);

    // Zero-latency streaming: one instruction per cycle, ending on the add at 0x20
    bus.ready = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    chk("add_instr", if_id_instr, 32'h0123_4820);
    chk("add_opcode", 32'(opcode), 32'h0);
    chk("add_func", 32'(func), 32'h20);
    chk("add_pc4", if_id_pc4, 32'h0000_0024);

    // 3-cycle latency ending under stall, stall held 2 more cycles
    stall = 1'b1;
    bus.ready = 1'b0;
    tick();
    tick();
    chk("stall_hold_instr", if_id_instr, 32'h0123_4820);
    bus.ready = 1'b1;
    tick();
    chk("hold_req", 32'(bus.req), 32'h0);
    bus.ready = 1'b0;
    tick();
    tick();
    chk("hold_req2", 32'(bus.req), 32'h0);
    chk("hold_instr", if_id_instr, 32'h0123_4820);
    stall = 1'b0;
    tick();
    chk("skid_instr", if_id_instr, mem_word(32'h0000_0024));
    chk("skid_pc4", if_id_pc4, 32'h0000_0028);
    chk("after_skid_addr", bus.addr, 32'h0000_0028);

    // Redirect to 0x100 while request pending, latency 2
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    tick();
    redirect_valid = 1'b0;
    chk("drain_addr", bus.addr, 32'h0000_0028);
    tick();
    bus.ready = 1'b1;
    tick();
    chk("drain_valid", 32'(if_id_valid), 32'h0);
    chk("redirect_addr", bus.addr, 32'h0000_0100);
    tick();

    // Stall and redirect together: redirect wins
    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0043;
    tick();
    stall          = 1'b0;
    redirect_valid = 1'b0;
    chk("sr_valid", 32'(if_id_valid), 32'h0);
    chk("sr_addr", bus.addr, 32'h0000_0040);
    tick();

    // Reset while a request is outstanding
    bus.ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_addr", bus.addr, 32'h0000_0000);
    chk("midrst_valid", 32'(if_id_valid), 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bus.ready      = ($urandom_range(0, 1) == 1);
      stall          = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc    = $urandom();
      rst            = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst            = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;

    // PC wrap from RESET_PC = 0xFFFF_FFFC
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("wrap_first_addr", bus_w.addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_second_addr", bus_w.addr, 32'h0000_0000);
    chk("wrap_pc4", w_pc4, 32'h0000_0000);
    chk("wrap_valid", 32'(w_valid), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS datapath.
- Keeps the fetch PC and issues requests to instruction memory over a req/ready handshake.
- Absorbs hazard stalls with a one-entry skid buffer and applies branch/jump redirects.
- Drives the registered instruction, PC+4, and the opcode/func fields consumed by the decode-stage control unit.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
ADDR_W, 32, PC/address width; instruction width fixed at 32

Ports:
clk  input  1  sole clock; all state updates on rising edge
rst  input  1  reset; synchronous, active-high
imem_req  output  1  fetch request valid
imem_addr  output  ADDR_W  fetch address; word aligned
imem_ready  input  1  response this cycle; imem_rdata valid only when high
imem_rdata  input  32  fetched instruction
stall  input  1  hazard unit: hold IF/ID contents
redirect_valid  input  1  taken branch/jump: squash and refetch
redirect_pc  input  ADDR_W  redirect target
if_id_valid  output  1  IF/ID holds a live instruction
if_id_instr  output  32  IF/ID instruction; 32'h0 when not valid
if_id_pc4  output  ADDR_W  address of instruction + 4
opcode  output  6  if_id_instr[31:26], combinational from register
func  output  6  if_id_instr[5:0], combinational from register

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset: state=REQ, pc_req=RESET_PC, if_id_valid=0, if_id_instr=0, if_id_pc4=0, skid empty.
  - imem_req is 1 from the first cycle after reset.
  - A request outstanding at reset is abandoned. Imem is reset by the same rst.
- Handshake:
  - While imem_req=1, imem_addr stays stable until a cycle with imem_ready=1. That cycle completes the transfer.
  - Memory latency is variable and may be zero, i.e. imem_ready in the same cycle req rises.
- Priority each cycle: rst > redirect_valid > stall > normal.
- Bubble: any cycle IF/ID is loaded without a live instruction gives if_id_valid=0 and if_id_instr=0. Opcode/func are then 000000/000000 (sll $0 NOP).
- Stall: while stall=1 and no redirect, if_id_* hold their values.
- State REQ (imem_req=1, imem_addr=pc_req):
  - redirect_valid & imem_ready: drop rdata; pc_req<=redirect_pc; IF/ID<=bubble; stay REQ.
  - redirect_valid & !imem_ready: pc_pend<=redirect_pc; IF/ID<=bubble; go to DRAIN.
  - imem_ready & !stall: IF/ID<={valid=1, rdata, pc_req+4}; pc_req<=pc_req+4; stay REQ. Back-to-back zero-latency fetches give 1 instr/cycle.
  - imem_ready & stall: skid<={rdata, pc_req+4}; pc_req<=pc_req+4; go to HOLD.
  - !imem_ready & !stall: IF/ID<=bubble.
- State HOLD (imem_req=0):
  - redirect_valid: discard skid; pc_req<=redirect_pc; IF/ID<=bubble; go to REQ.
  - !stall: IF/ID<=skid with valid=1; go to REQ.
  - stall: hold.
- State DRAIN (imem_req=1, imem_addr = old pc_req, held stable):
  - Another redirect_valid updates pc_pend (latest wins). IF/ID<=bubble.
  - imem_ready: drop rdata; pc_req<=pc_pend; go to REQ. Any redirect arriving in this same cycle takes precedence as the new pc_req.
  - No instruction from a squashed path ever reaches IF/ID.
- PC arithmetic: +4 modulo 2^ADDR_W; 32'hFFFF_FFFC wraps to 0. redirect_pc[1:0] is ignored and forced to 00.
- Stall and redirect in the same cycle: redirect wins. IF/ID becomes a bubble even though stall=1.

Test Plan:
- Reset, RESET_PC=0, imem_ready tied 1, rdata=addr-derived -> imem_addr 0,4,8,... one per cycle; IF/ID valid from 2nd cycle; if_id_pc4 = addr+4.
- Instr 32'h0123_4820 (add) fetched -> opcode=000000, func=100000, if_id_valid=1.
- 3-cycle latency, stall high when response arrives, then held 2 cycles -> imem_req drops during HOLD; IF/ID unchanged during stall; skid instr appears in the cycle after stall falls; next addr = +4.
- redirect_valid to 0x100 in a cycle with imem_ready=0, latency 2 -> imem_addr stays old until ready; response dropped; next request to 0x100; if_id_valid=0 throughout.
- Simultaneous stall=1 and redirect_valid to 0x40 -> IF/ID bubble next cycle; next fetch 0x40.
- RESET_PC=32'hFFFF_FFFC -> second fetch address 0; rst asserted mid-request -> next cycle imem_addr=RESET_PC and if_id_valid=0.
